// File: rtl/led_pattern_bank.sv
// Multi-channel LED pattern generator: a shared tick prescaler plus per-channel
// OFF / ON / BLINK / BREATHE engines, with registered active-low-capable pins.
module led_pattern_bank #(
    parameter int CHANNELS   = 6,
    parameter int TICK_DIV   = 27000,
    parameter int CNT_W      = 16,
    parameter int INIT_HALF  = 500,
    parameter int ACTIVE_LOW = 1,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [1:0]          wr_mode,
    input  logic [CNT_W-1:0]    wr_half,
    input  logic                sync,
    output logic                tick,
    output logic [CHANNELS-1:0] led
);

    // wr_en and sync are single-cycle strobes with no back-pressure: the block
    // is always ready and acts on the strobe at the edge that captures it.

    localparam int   PW = $clog2(TICK_DIV);
    localparam logic AL = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    logic [PW-1:0]       pcnt;
    logic [7:0]          pwm;
    logic [CHANNELS-1:0] lit_eff;

    // Reload value H-1 with H = max(h,1), so a zero interval behaves as one tick.
    function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] h);
        return (h == '0) ? '0 : h - CNT_W'(1);
    endfunction

    assign tick = (pcnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            pwm  <= '0;
        end else if (sync) begin
            pcnt <= '0;
            pwm  <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
            pwm  <= pwm + 8'd1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        mode_t            mode_r;
        logic [CNT_W-1:0] half_r;
        logic [CNT_W-1:0] cnt_r;
        logic             lit_r;
        logic [7:0]       duty_r;
        logic             dir_r;
        logic             wr_hit;
        logic             lit_e;

        assign wr_hit = wr_en && (wr_ch == CH_W'(i));

        // A restart (sync or write) takes priority over a coincident tick.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_r <= MODE_BLINK;
                half_r <= CNT_W'(INIT_HALF);
                cnt_r  <= CNT_W'(INIT_HALF - 1);
                lit_r  <= 1'b0;
                duty_r <= 8'd0;
                dir_r  <= 1'b1;
            end else if (sync || wr_hit) begin
                if (wr_hit) begin
                    mode_r <= mode_t'(wr_mode);
                    half_r <= wr_half;
                    cnt_r  <= reload(wr_half);
                end else begin
                    cnt_r  <= reload(half_r);
                end
                lit_r  <= 1'b0;
                duty_r <= 8'd0;
                dir_r  <= 1'b1;
            end else if (tick) begin
                if (cnt_r == '0) begin
                    cnt_r <= reload(half_r);
                    if (mode_r == MODE_BLINK) begin
                        lit_r <= ~lit_r;
                    end
                    if (mode_r == MODE_BREATHE) begin
                        // Turn around on reaching an endpoint so each endpoint lasts one step.
                        if (dir_r) begin
                            duty_r <= duty_r + 8'd1;
                            if (duty_r == 8'd254) dir_r <= 1'b0;
                        end else begin
                            duty_r <= duty_r - 8'd1;
                            if (duty_r == 8'd1) dir_r <= 1'b1;
                        end
                    end
                end else begin
                    cnt_r <= cnt_r - CNT_W'(1);
                end
            end
        end

        always_comb begin
            lit_e = 1'b0;
            case (mode_r)
                MODE_OFF:     lit_e = 1'b0;
                MODE_ON:      lit_e = 1'b1;
                MODE_BLINK:   lit_e = lit_r;
                MODE_BREATHE: lit_e = (duty_r > pwm);
                default:      lit_e = 1'b0;
            endcase
        end

        assign lit_eff[i] = lit_e;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= {CHANNELS{AL}};
        end else begin
            led <= lit_eff ^ {CHANNELS{AL}};
        end
    end

endmodule

// File: tb/tb_led_pattern_bank.sv
// Scoreboard bench for led_pattern_bank: a tick-count reference model predicts
// led/tick per clock, and a negedge monitor pops and compares each prediction.
module tb_led_pattern_bank;

  localparam int CHANNELS   = 3;
  localparam int TICK_DIV   = 4;
  localparam int CNT_W      = 8;
  localparam int INIT_HALF  = 2;
  localparam int ACTIVE_LOW = 1;
  localparam int W          = CHANNELS + 1;

  localparam int M_OFF     = 0;
  localparam int M_ON      = 1;
  localparam int M_BLINK   = 2;
  localparam int M_BREATHE = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                wr_en = 1'b0;
  logic [1:0]          wr_ch = '0;
  logic [1:0]          wr_mode = '0;
  logic [CNT_W-1:0]    wr_half = '0;
  logic                sync = 1'b0;
  logic                tick;
  logic [CHANNELS-1:0] led;

  led_pattern_bank #(
    .CHANNELS  (CHANNELS),
    .TICK_DIV  (TICK_DIV),
    .CNT_W     (CNT_W),
    .INIT_HALF (INIT_HALF),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_mode(wr_mode),
    .wr_half(wr_half),
    .sync   (sync),
    .tick   (tick),
    .led    (led)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: clocks since the last reset/sync, and per channel the
  // number of ticks seen since that channel last restarted.
  int m_pclk;
  int m_mode[CHANNELS];
  int m_half[CHANNELS];
  int m_ticks[CHANNELS];

  function automatic int triangle(input int n);
    int s;
    s = n % 510;
    return (s <= 255) ? s : 510 - s;
  endfunction

  function automatic logic model_lit(input int ch);
    int h;
    int n;
    h = (m_half[ch] == 0) ? 1 : m_half[ch];
    n = m_ticks[ch] / h;
    case (m_mode[ch])
      M_ON:      return 1'b1;
      M_BLINK:   return (n % 2) == 1;
      M_BREATHE: return triangle(n) > (m_pclk % 256);
      default:   return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [CHANNELS-1:0] e_led;
    logic is_tick;
    logic hit;
    if (!rst_n) begin
      m_pclk = 0;
      for (int i = 0; i < CHANNELS; i++) begin
        m_mode[i]  = M_BLINK;
        m_half[i]  = INIT_HALF;
        m_ticks[i] = 0;
      end
      exp_q.push_back({1'b0, {CHANNELS{1'b1}}});
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        e_led[i] = model_lit(i) ^ (ACTIVE_LOW != 0);
      end
      is_tick = (m_pclk % TICK_DIV) == (TICK_DIV - 1);
      if (sync) m_pclk = 0;
      else m_pclk++;
      for (int i = 0; i < CHANNELS; i++) begin
        hit = wr_en && (int'(wr_ch) == i);
        if (hit) begin
          m_mode[i] = int'(wr_mode);
          m_half[i] = int'(wr_half);
        end
        if (sync || hit) m_ticks[i] = 0;
        else if (is_tick) m_ticks[i]++;
      end
      exp_q.push_back({((m_pclk % TICK_DIV) == (TICK_DIV - 1)), e_led});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led !== e[CHANNELS-1:0]) begin
        errors++;
        $display("FAIL led: got %b expected %b at %0t", led, e[CHANNELS-1:0], $time);
      end
      checks++;
      if (tick !== e[W-1]) begin
        errors++;
        $display("FAIL tick: got %b expected %b at %0t", tick, e[W-1], $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input int ch, input int mode, input int half);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_mode = 2'(mode);
    wr_half = CNT_W'(half);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic do_sync();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_wait: got %b expected 1 within 16 cycles", tick);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int r;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 3'b111) begin
      errors++;
      $display("FAIL reset_led: got %b expected 111", led);
    end
    rst_n = 1'b1;
    cyc(30);

    do_write(1, M_ON, 2);
    cyc(6);
    do_write(2, M_OFF, 2);
    cyc(20);

    do_write(3, M_ON, 5);
    cyc(10);
    do_write(0, M_BLINK, 0);
    cyc(20);

    // Sync and write together, landing on a tick cycle.
    wait_tick();
    sync    = 1'b1;
    wr_en   = 1'b1;
    wr_ch   = 2'd0;
    wr_mode = 2'(M_BLINK);
    wr_half = CNT_W'(3);
    @(negedge clk);
    sync  = 1'b0;
    wr_en = 1'b0;
    cyc(40);

    do_write(0, M_BREATHE, 1);
    cyc(2100);

    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        do_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (r == 4) begin
        do_sync();
      end else if (r == 5) begin
        sync = 1'b1;
        do_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        sync = 1'b0;
      end else begin
        cyc(1);
      end
    end

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 3'b111) begin
      errors++;
      $display("FAIL async_reset_led: got %b expected 111", led);
    end
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_tick: got %b expected 0", tick);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(40);

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_bank.md
# led_pattern_bank

Multi-channel LED pattern generator for the Tang Nano 9k: one instance drives `CHANNELS` LEDs from a single clock. Each channel is independently programmable for mode (off, on, blink, breathe) and rate. A shared prescaler generates the time base. The block sits between board-level control logic (buttons, UART command decoder, PLL-lock status) and the LED pins, replacing ad-hoc per-LED blinker instances.

## Interface
- `CHANNELS`, 6: number of LED channels, 1..16.
- `TICK_DIV`, 27000: clocks per time-base tick (1 ms at 27 MHz), ≥2.
- `CNT_W`, 16: width of the per-channel half-period / step-interval field, in ticks.
- `INIT_HALF`, 500: reset value of every channel's half-period, ≥1.
- `ACTIVE_LOW`, 1: 1 means a lit LED is driven 0 (board LEDs are active-low).

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: channel configuration write strobe, one cycle.
- `wr_ch` in max(1,$clog2(CHANNELS)): target channel index.
- `wr_mode` in 2: mode encoding: 0=OFF, 1=ON, 2=BLINK, 3=BREATHE.
- `wr_half` in CNT_W: half-period (BLINK) or step interval (BREATHE), in ticks.
- `sync` in 1: one-cycle strobe that restarts the prescaler and re-phases all channels.
- `tick` out 1: one-cycle time-base pulse, for debug and chaining.
- `led` out CHANNELS: LED pins, polarity per `ACTIVE_LOW`.

## Operation
- Prescaler: `pcnt` counts 0..TICK_DIV-1 and wraps. `tick`=1 for the single cycle in which `pcnt`==TICK_DIV-1.
- Per-channel state:
  - `mode` (2 b), `half` (CNT_W).
  - `cnt` (CNT_W): tick down-counter.
  - `lit` (1 b).
  - `duty` (8 b), `dir` (1 b, 1=up).
- Shared `pwm` is an 8-bit free-running counter, incremented every clock.
- Effective interval is H = max(`half`,1); `half`=0 behaves as 1.
- Mode behaviour:
  - OFF: `lit`=0.
  - ON: `lit`=1.
  - BLINK: on each tick, if `cnt`==0 then toggle `lit` and set `cnt`=H-1; otherwise decrement `cnt`. Full period is 2·H·TICK_DIV clocks.
  - BREATHE: on each tick, if `cnt`==0 then set `cnt`=H-1 and step `duty` by ±1 per `dir`; otherwise decrement `cnt`.
    - When `duty` reaches 255 going up, `dir` becomes 0. When it reaches 0 going down, `dir` becomes 1. Endpoints are held for exactly one step, with no skipping or overflow.
    - `lit` = (`duty` > `pwm`), evaluated every clock.
- Write: `wr_en` with `wr_ch` < CHANNELS loads `mode`=`wr_mode` and `half`=`wr_half`, and restarts the channel: `cnt`=H'-1 (H' from `wr_half`), `lit`=0, `duty`=0, `dir`=1. A write with `wr_ch` ≥ CHANNELS is ignored entirely.
- Sync:
  - `pcnt`=0 and `pwm`=0.
  - Every channel: `cnt`=H-1, `lit`=0, `duty`=0, `dir`=1. `mode` and `half` are unchanged.
- `sync` and `wr_en` in the same cycle: the sync applies to all channels, and the written channel additionally takes the new `mode`/`half`, with `cnt` reloaded from `wr_half`.
- `sync` or a write on a tick cycle: the restart wins, and that tick causes no toggle and no step on the affected channels.
- Output: `led[i]` = `lit[i]` XOR ACTIVE_LOW, registered, so the pin is a flop output.

## Timing
- Reset (asynchronous, immediate):
  - `pcnt`=0, `pwm`=0, `tick`=0.
  - All channels: `mode`=BLINK, `half`=INIT_HALF, `cnt`=INIT_HALF-1, `lit`=0, `duty`=0, `dir`=1.
  - `led` = all ACTIVE_LOW (LEDs dark).
- Deassertion of `rst_n` is synchronised externally; the block needs no internal release stage.
- First tick occurs in the TICK_DIV-th clock after reset or sync.
- Write/sync latency: state changes at the capturing edge. `led` reflects the new `lit` one edge later.
  - An ON write at edge k gives `led` lit after edge k+1.
- BLINK: first toggle after a restart happens on the H-th tick. Subsequent toggles occur every H ticks.
- BREATHE: the `led` duty is `duty`/256 over each 256-clock `pwm` window. A full ramp up and down takes 510·H ticks.

## Test plan
Bench parameters: CHANNELS=3, TICK_DIV=4, CNT_W=8, INIT_HALF=2, ACTIVE_LOW=1.
- Reset: hold `rst_n`=0, then release. Required: `led`=3'b111 during reset; `tick` pulses at clocks 4, 8, 12…; all `led` bits go to 0 one cycle after the 2nd tick; they then toggle every 8 clocks in phase.
- Mode writes: pulse `wr_en` with ch1 mode=ON, then ch2 mode=OFF. Required: `led[1]`=0 and `led[2]`=1 from the second edge after each write and stable afterwards; `led[0]` continues blinking undisturbed.
- Ignored write plus zero half: write `wr_ch`=3. Required: no change on any channel. Then write ch0 BLINK with `half`=0. Required: ch0 toggles on every tick (every 4 clocks).
- Simultaneous sync and write: pulse `sync` and `wr_en` (ch0 BLINK, half=3) in the same cycle, landing on a tick cycle. Required: that tick is suppressed; ch0 first toggles 12 clocks later; ch1/ch2 re-phase to the 2-tick interval from the same origin.
- Breathe: write ch0 BREATHE with half=1. Required:
  - `duty` reaches 255 after 255 ticks, then decrements, then reaches 0 at tick 510.
  - Measured `led[0]` low-time per 256-clock window equals `duty`, checked at duty 0, 128 and 255.
- Reset mid-operation: assert `rst_n`=0 asynchronously between clock edges. Required: `led`=3'b111 with no clock edge; all registers return to their reset values.
